// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: appends SHA-256 padding (0x80, zero fill, 64-bit bit length) to a byte stream
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_start,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, MSG, PAD80, ZERO, LEN, DRAIN} state_t;
  state_t state, state_n;
  logic [LEN_W-1:0] len_cnt;
  logic [5:0] pos, pos_inc;
  logic empty, free, load, ld_last;
  logic [7:0] ld_data;
  logic [63:0] bit_len, len_sh;
  assign free = !m_valid || m_ready;
  assign s_ready = !rst && state == MSG && free;
  assign m_start = state == START;
  assign busy = state != IDLE;
  assign pos_inc = pos + 6'd1;
  assign bit_len = 64'({len_cnt, 3'b000});
  // length bytes occupy pos 56..63, so pos[2:0] selects the byte MSB first
  assign len_sh = bit_len >> {~pos[2:0], 3'b000};
  always_comb begin
    state_n = state;
    load = 1'b0;
    ld_data = 8'h00;
    ld_last = 1'b0;
    case (state)
      IDLE:  if (s_start) state_n = START;
      START: state_n = empty ? PAD80 : MSG;
      MSG: if (s_valid && free) begin
        load = 1'b1;
        ld_data = s_data;
        if (s_last) state_n = PAD80;
      end
      PAD80: if (free) begin
        load = 1'b1;
        ld_data = 8'h80;
        state_n = pos_inc == 6'd56 ? LEN : ZERO;
      end
      ZERO: if (free) begin
        load = 1'b1;
        if (pos_inc == 6'd56) state_n = LEN;
      end
      LEN: if (free) begin
        load = 1'b1;
        ld_data = len_sh[7:0];
        ld_last = pos == 6'd63;
        if (ld_last) state_n = DRAIN;
      end
      DRAIN: if (free) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_cnt <= '0;
      pos <= '0;
      empty <= 1'b0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && s_start) begin
        len_cnt <= '0;
        pos <= '0;
        empty <= s_last && !s_valid;
      end
      if (state == MSG && load) len_cnt <= len_cnt + LEN_W'(1);
      if (load) begin
        m_data <= ld_data;
        m_valid <= 1'b1;
        m_last <= ld_last;
        pos <= pos_inc;
      end else if (free) begin
        m_valid <= 1'b0;
        m_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: table-driven and randomized checks of the padder against a padding model
module tb_sha256_msg_padder;
  logic clk = 0, rst = 1, s_start = 0, s_valid = 0, s_last = 0, m_ready = 1;
  logic [7:0] s_data = 0;
  logic s_ready, m_start, m_valid, m_last, busy;
  logic [7:0] m_data;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .s_start(s_start), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .m_start(m_start), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int n; int mode; int total;} vec_t;
  vec_t tbl[8];
  int n_chk = 0, n_fail = 0;
  logic [7:0] msg[$], got[$], t1[$];
  bit gotl[$];
  int starts = 0, rmode = 0, stall_left = 10;
  logic pv = 0, pr = 0, pl = 0;
  logic [7:0] pd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // padded stream: message, 0x80, zeros, 64-bit big-endian bit count, total a multiple of 64
  function automatic logic [7:0] exp_byte(input int n, input int i);
    int total;
    logic [63:0] bl;
    total = ((n + 9 + 63) / 64) * 64;
    bl = 64'(n) * 64'd8;
    if (i < n) return msg[i];
    if (i == n) return 8'h80;
    if (i >= total - 8) return 8'(bl >> (8 * (total - 1 - i)));
    return 8'h00;
  endfunction

  function automatic int diff_t1();
    int d = 0;
    if (got.size() != t1.size()) d++;
    for (int i = 0; i < t1.size() && i < got.size(); i++) if (got[i] !== t1[i]) d++;
    return d;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, pl, pd});
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        gotl.push_back(m_last);
      end
      if (m_start) starts++;
    end
    pv = m_valid && !rst;
    pr = m_ready;
    pd = m_data;
    pl = m_last;
  end

  // mode 0: always ready, 1: random, 2: 10-cycle stall at byte 30 then toggle
  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 0) m_ready = 1;
    else if (rmode == 1) m_ready = 1'($urandom_range(0, 1));
    else if (got.size() == 30 && stall_left > 0) begin
      m_ready = 0;
      stall_left--;
    end else if (got.size() >= 30) m_ready = !m_ready;
    else m_ready = 1;
  end

  task automatic run_msg(input int n, input int mode, input int pulse_at, input int rst_at, input int total);
    bit acc;
    int bad, nl;
    got.delete();
    gotl.delete();
    starts = 0;
    rmode = mode;
    stall_left = 10;
    if (n == 0) begin
      s_start = 1;
      s_last = 1;
      @(posedge clk);
      #1;
      s_start = 0;
      s_last = 0;
    end
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        s_valid = 0;
        s_last = 0;
        rst = 1;
        @(negedge clk);
        chk("s_ready_in_rst", s_ready, 0);
        @(negedge clk);
        chk("mid_rst_outputs", {m_valid, m_last, m_start, busy, m_data}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        return;
      end
      acc = 0;
      s_valid = 1;
      s_data = msg[i];
      s_last = (i == n - 1);
      for (int k = 0; k < 300 && !acc; k++) begin
        s_start = (k == 0) && (i == 0 || i == pulse_at);
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
      end
      s_start = 0;
      if (!acc) begin
        chk("accept_timeout", acc, 1);
        break;
      end
    end
    s_valid = 0;
    s_last = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy && got.size() >= total) break;
    end
    @(posedge clk);
    #1;
    chk("out_len", got.size(), total);
    chk("idle_after", busy, 0);
    bad = total;
    for (int i = 0; i < total && i < got.size(); i++)
      if (got[i] !== exp_byte(n, i) && bad == total) bad = i;
    chk("first_bad_byte_idx", bad, total);
    nl = 0;
    foreach (gotl[i]) if (gotl[i]) nl++;
    chk("last_count", nl, 1);
    chk("last_on_final", got.size() > 0 ? gotl[got.size() - 1] : 1'b0, 1);
    chk("start_pulses", starts, 1);
  endtask

  initial begin
    tbl[0] = '{0, 0, 64};
    tbl[1] = '{3, 1, 64};
    tbl[2] = '{55, 0, 64};
    tbl[3] = '{56, 1, 128};
    tbl[4] = '{63, 1, 128};
    tbl[5] = '{64, 0, 128};
    tbl[6] = '{119, 1, 128};
    tbl[7] = '{120, 1, 192};
    s_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {m_valid, m_last, m_start, busy, s_ready, m_data}, 0);
    @(posedge clk);
    #1;
    s_valid = 0;
    rst = 0;
    @(posedge clk);
    #1;
    // T1 "abc"
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(3, 0, -1, -1, 64);
    chk("abc_b0", got[0], 8'h61);
    chk("abc_b3", got[3], 8'h80);
    chk("abc_b62", got[62], 8'h00);
    chk("abc_b63", got[63], 8'h18);
    t1 = got;
    // T2 empty message
    msg.delete();
    run_msg(0, 0, -1, -1, 64);
    chk("empty_b0", got[0], 8'h80);
    chk("empty_b63", got[63], 8'h00);
    // table of lengths around the block boundaries, random content
    foreach (tbl[v]) begin
      msg.delete();
      for (int j = 0; j < tbl[v].n; j++) msg.push_back(8'($urandom));
      run_msg(tbl[v].n, tbl[v].mode, -1, -1, tbl[v].total);
    end
    // T3 56 bytes spill into a second block
    msg.delete();
    for (int j = 0; j < 56; j++) msg.push_back(8'($urandom));
    run_msg(56, 0, -1, -1, 128);
    chk("m56_b56", got[56], 8'h80);
    chk("m56_b126", got[126], 8'h01);
    chk("m56_b127", got[127], 8'hc0);
    msg.delete();
    for (int j = 0; j < 55; j++) msg.push_back(8'($urandom));
    run_msg(55, 0, -1, -1, 64);
    chk("m55_b62", got[62], 8'h01);
    chk("m55_b63", got[63], 8'hb8);
    // T4 backpressure reproduces T1
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(3, 2, -1, -1, 64);
    chk("bp_vs_t1", diff_t1(), 0);
    // T5 s_start during MSG ignored
    msg.delete();
    for (int j = 0; j < 40; j++) msg.push_back(8'($urandom));
    run_msg(40, 1, 10, -1, 64);
    // T5 reset at byte 20, then fresh abc
    run_msg(40, 0, -1, 20, 64);
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(3, 0, -1, -1, 64);
    chk("post_rst_vs_t1", diff_t1(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
